// File: rtl/mod_mult_barrett_if.sv
// mod_mult_barrett_if: stall/valid operand and result bundle for the Barrett multiplier
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif
interface mod_mult_barrett_if #(
  parameter int DATA_W = `DATA_SIZE_ARB,
  parameter int K = `DATA_SIZE_ARB
) ();
  logic stall;
  logic in_valid;
  logic sel_in;
  logic [DATA_W-1:0] q;
  logic [K:0] mu;
  logic [DATA_W-1:0] u_in;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] w_in;
  logic out_valid;
  logic sel_out;
  logic [DATA_W-1:0] u_out;
  logic [DATA_W-1:0] v_out;
  modport slave (
    input stall, in_valid, sel_in, q, mu, u_in, a_in, w_in,
    output out_valid, sel_out, u_out, v_out
  );
  modport master (
    output stall, in_valid, sel_in, q, mu, u_in, a_in, w_in,
    input out_valid, sel_out, u_out, v_out
  );
endinterface

// File: rtl/mod_mult_barrett.sv
// mod_mult_barrett: 4-stage pipelined Barrett (a*w) mod q with time-aligned u/sel passthrough and global stall
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif
module mod_mult_barrett #(
  parameter int DATA_W = `DATA_SIZE_ARB,
  parameter int K = `DATA_SIZE_ARB
) (
  input logic clk,
  input logic reset,
  mod_mult_barrett_if.slave bus
);
  localparam int PW = 2 * DATA_W;
  localparam int TW = 2 * K + 2;
  localparam int QW = DATA_W + K + 1;
  localparam int CW = DATA_W + 2;
  logic [PW-1:0] prod;
  logic [TW-1:0] t;
  logic [QW-1:0] qq;
  logic [CW-1:0] rx, qx, q2, red;
  logic [2*K-1:0] p1_q, p1_d, p2_q;
  logic [K:0] qhat_q, qhat_d;
  logic [K+1:0] r_q, r_d;
  logic [DATA_W-1:0] v_q, v_d;
  logic [3:0][DATA_W-1:0] u_q;
  logic [3:0] vld_q, sel_q;
  logic unused_bits;
  // Stage arithmetic: product, quotient estimate, remainder mod 2^(K+2), final conditional subtraction
  always_comb begin
    prod = PW'(bus.a_in) * PW'(bus.w_in);
    p1_d = prod[2*K-1:0];
    t = TW'(p1_q[2*K-1:K-1]) * TW'(bus.mu);
    qhat_d = t[TW-1:K+1];
    qq = QW'(qhat_q) * QW'(bus.q);
    r_d = p2_q[K+1:0] - qq[K+1:0];
    rx = CW'(r_q);
    qx = CW'(bus.q);
    q2 = qx << 1;
    red = rx >= q2 ? rx - q2 : rx >= qx ? rx - qx : rx;
    v_d = red[DATA_W-1:0];
  end
  assign unused_bits = ^{prod, t, qq, p2_q, red};
  // Pipeline registers: all advance together unless stalled; reset discards every in-flight beat
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      p1_q <= '0;
      p2_q <= '0;
      qhat_q <= '0;
      r_q <= '0;
      v_q <= '0;
      u_q <= '0;
      vld_q <= '0;
      sel_q <= '0;
    end else if (!bus.stall) begin
      p1_q <= p1_d;
      p2_q <= p1_q;
      qhat_q <= qhat_d;
      r_q <= r_d;
      v_q <= v_d;
      u_q <= {u_q[2:0], bus.u_in};
      vld_q <= {vld_q[2:0], bus.in_valid};
      sel_q <= {sel_q[2:0], bus.sel_in};
    end
  assign bus.out_valid = vld_q[3];
  assign bus.sel_out = sel_q[3];
  assign bus.u_out = u_q[3];
  assign bus.v_out = v_q;
endmodule

// File: tb/tb_mod_mult_barrett.sv
// tb_mod_mult_barrett: scoreboard bench for two Barrett multipliers (q=12289 K=14, q=3329 K=12)
module tb_mod_mult_barrett;
  localparam int DW = 16;
  typedef struct {
    logic [15:0] v;
    logic [15:0] u;
    logic sel;
    int adv;
  } exp_t;
  logic clk = 0;
  logic reset = 0;
  logic stall = 0, vld = 0, sel = 0;
  logic [15:0] u = 0, a_a = 0, w_a = 0, a_b = 0, w_b = 0;
  logic st_prev = 0;
  logic [33:0] snap_a = 0, snap_b = 0;
  int checks = 0, failures = 0, adv = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  mod_mult_barrett_if #(.DATA_W(DW), .K(14)) ia ();
  mod_mult_barrett_if #(.DATA_W(DW), .K(12)) ib ();
  mod_mult_barrett #(.DATA_W(DW), .K(14)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  mod_mult_barrett #(.DATA_W(DW), .K(12)) dut_b (.clk(clk), .reset(reset), .bus(ib));
  assign ia.stall = stall;
  assign ia.in_valid = vld;
  assign ia.sel_in = sel;
  assign ia.u_in = u;
  assign ia.a_in = a_a;
  assign ia.w_in = w_a;
  assign ia.q = 16'd12289;
  assign ia.mu = 15'd21843;
  assign ib.stall = stall;
  assign ib.in_valid = vld;
  assign ib.sel_in = sel;
  assign ib.u_in = u;
  assign ib.a_in = a_b;
  assign ib.w_in = w_b;
  assign ib.q = 16'd3329;
  assign ib.mu = 13'd5039;
  always #5 clk = ~clk;
  function automatic logic [15:0] model(logic [15:0] a, logic [15:0] w, int q);
    return 16'((longint'(a) * longint'(w)) % longint'(q));
  endfunction
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic step(int va = -1);
    a_b = 16'($urandom_range(3328));
    w_b = 16'($urandom_range(3328));
    if (vld && !stall) begin
      qa.push_back('{va < 0 ? model(a_a, w_a, 12289) : 16'(va), u, sel, adv + 4});
      qb.push_back('{model(a_b, w_b, 3329), u, sel, adv + 4});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic rnd_a();
    a_a = 16'($urandom_range(12288));
    w_a = 16'($urandom_range(12288));
  endtask
  always @(posedge clk) begin
    st_prev <= stall;
    if (reset && !stall) adv <= adv + 1;
  end
  always @(negedge clk) begin
    if (reset) begin
      if (st_prev) chk("hold_a", {ia.out_valid, ia.sel_out, ia.u_out, ia.v_out}, snap_a);
      else if (ia.out_valid) begin
        chk("expected_beat_a", 1'(qa.size() != 0), ia.out_valid);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          chk("v_a", ia.v_out, ea.v);
          chk("u_a", ia.u_out, ea.u);
          chk("sel_a", ia.sel_out, ea.sel);
          chk("latency_a", adv, ea.adv);
        end
      end
    end
    snap_a = {ia.out_valid, ia.sel_out, ia.u_out, ia.v_out};
  end
  always @(negedge clk) begin
    if (reset) begin
      if (st_prev) chk("hold_b", {ib.out_valid, ib.sel_out, ib.u_out, ib.v_out}, snap_b);
      else if (ib.out_valid) begin
        chk("expected_beat_b", 1'(qb.size() != 0), ib.out_valid);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          chk("v_b", ib.v_out, eb.v);
          chk("u_b", ib.u_out, eb.u);
          chk("sel_b", ib.sel_out, eb.sel);
          chk("latency_b", adv, eb.adv);
        end
      end
    end
    snap_b = {ib.out_valid, ib.sel_out, ib.u_out, ib.v_out};
  end
  initial begin
    logic [15:0] ca [4];
    logic [15:0] cw [4];
    logic [15:0] cv [4];
    ca = '{16'd12288, 16'd0, 16'd2, 16'd5000};
    cw = '{16'd12288, 16'd7, 16'd6145, 16'd7000};
    cv = '{16'd1, 16'd0, 16'd1, 16'd928};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid_a", ia.out_valid, 0);
    chk("reset_v_a", ia.v_out, 0);
    chk("reset_valid_b", ib.out_valid, 0);
    reset = 1;
    vld = 1;
    for (int i = 0; i < 3; i++) begin
      rnd_a();
      u = 16'(100 + i);
      sel = 1;
      step();
    end
    vld = 0;
    step();
    #2 reset = 0;
    #1;
    qa.delete();
    qb.delete();
    chk("midrst_valid_a", ia.out_valid, 0);
    chk("midrst_v_a", ia.v_out, 0);
    chk("midrst_u_a", ia.u_out, 0);
    chk("midrst_sel_a", ia.sel_out, 0);
    chk("midrst_valid_b", ib.out_valid, 0);
    @(posedge clk);
    #1;
    reset = 1;
    repeat (6) step();
    vld = 1;
    for (int i = 0; i < 4; i++) begin
      a_a = ca[i];
      w_a = cw[i];
      u = 16'(i);
      sel = i[0];
      step(int'(cv[i]));
    end
    vld = 0;
    repeat (6) step();
    vld = 1;
    for (int i = 0; i < 8; i++) begin
      rnd_a();
      u = 16'(i);
      sel = i[0];
      step();
    end
    vld = 0;
    repeat (6) step();
    vld = 1;
    for (int i = 0; i < 2; i++) begin
      rnd_a();
      u = 16'(40 + i);
      sel = ~i[0];
      step();
    end
    vld = 0;
    step();
    stall = 1;
    vld = 1;
    rnd_a();
    u = 16'hdead;
    repeat (3) step();
    stall = 0;
    vld = 0;
    repeat (6) step();
    for (int i = 0; i < 5; i++) begin
      vld = (i == 0 || i == 3);
      rnd_a();
      u = 16'(60 + i);
      sel = 0;
      step();
    end
    vld = 0;
    repeat (6) step();
    for (int i = 0; i < 10000; i++) begin
      stall = ($urandom_range(3) == 0);
      vld = ($urandom_range(9) < 7);
      rnd_a();
      u = 16'($urandom);
      sel = 1'($urandom);
      step();
    end
    stall = 0;
    vld = 0;
    repeat (8) step();
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mod_mult_barrett.md
Name: mod_mult_barrett

Overview:
- Pipelined Barrett modular multiplier: v = (a·w) mod q.
- Sits directly upstream of the NTT butterfly add/sub combiner. It produces the twiddle-multiplied operand, plus the time-aligned untouched operand and the add/sub select, so the combiner's two data inputs and select arrive together.
- Fixed 4-cycle latency, valid-tagged, with a global stall.

Parameters:
- DATA_W, default `DATA_SIZE_ARB: datapath width of all operand and result ports.
- K, default `DATA_SIZE_ARB: bit length of q, with 2^(K-1) ≤ q < 2^K and K ≤ DATA_W. Sets the Barrett shifts.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous active-low reset.
- stall, in, 1: 1 freezes the entire pipeline.
- in_valid, in, 1: input beat present; accepted when stall=0.
- sel_in, in, 1: butterfly add/sub select, passed through.
- q, in, DATA_W: modulus; quasi-static.
- mu, in, K+1: Barrett constant floor(2^(2K)/q); quasi-static.
- u_in, in, DATA_W: unmultiplied butterfly operand, passed through.
- a_in, in, DATA_W: multiplicand, < q.
- w_in, in, DATA_W: twiddle factor, < q.
- out_valid, out, 1: result beat valid.
- sel_out, out, 1: delayed sel_in.
- u_out, out, DATA_W: delayed u_in.
- v_out, out, DATA_W: (a_in·w_in) mod q.

Behaviour:
- Reset (reset=0, asynchronous): all pipeline valids clear; all data registers and outputs go to 0. Takes effect immediately, including mid-operation; in-flight beats are discarded, not flushed.
- Release: first beat may be accepted on the first rising edge with reset=1.
- Advance rule: when stall=0, every stage register loads from its predecessor on each edge, and stage 1 loads the inputs.
- Hold rule: when stall=1, all registers hold, including valids and outputs; inputs are ignored.
- Bubbles: in_valid=0 with stall=0 inserts a bubble (valid=0 propagates). Data registers may still load; downstream must qualify with valid.
- Latency: a beat accepted at edge N appears on the outputs after edge N+3, i.e. 4 register stages, assuming no stalls. Each stalled cycle adds exactly one cycle. Throughput is 1 beat/cycle.
- Stage 1: P = a_in·w_in, full 2K-bit product (upper input bits are zero since a, w < q). Register P, u, sel, valid.
- Stage 2: T = (P >> (K-1)) · mu. T has K+1 + K+1 bits. Register qhat = T >> (K+1), K+1 bits, and carry P forward.
- Stage 3: r = P − qhat·q, computed modulo 2^(K+2); guaranteed 0 ≤ r < 3q. Register r as K+2 bits.
- Stage 4: if r ≥ 2q, r −= 2q; else if r ≥ q, r −= q. Zero-extend to DATA_W and register into v_out. u_out, sel_out and out_valid are registered in the same stage.
- Operand contract: a_in ≥ q or w_in ≥ q is out of contract; the output is unspecified but the pipeline must not lock up.
- Configuration changes: q and mu may change only when the pipeline is empty (no valid in any stage). Changing them with beats in flight gives unspecified results for those beats only.
- Passthrough integrity: u and sel pass through bit-exact and never interact with the arithmetic.
- Simultaneous stall=1 and in_valid=1: the beat is not accepted. The source must hold it until stall=0.

Test Plan (DATA_W=16, K=14, q=12289, mu=21843):
- Reset mid-stream: issue 3 beats, assert reset=0 after the 2nd cycle → outputs immediately 0, out_valid=0. After release, no stale beat ever emerges.
- Corner values: (a,w) = (12288,12288) → v=1; (0,7) → v=0; (2,6145) → v=1; (5000,7000) → v=928. Each v_out appears 4 cycles after in_valid, with out_valid=1 for exactly one cycle.
- Back-to-back with passthrough: 8 consecutive random valid beats, u_in = index, sel_in alternating → 8 consecutive outputs. v matches a reference model; u_out = 0..7 in order; sel_out alternates in step.
- Stall: stall=1 for 3 cycles while 2 beats are in flight → outputs and out_valid frozen. Results emerge 3 cycles late, unchanged, with no duplicates or drops. A beat presented during the stall is not accepted.
- Bubbles: valid pattern 1,0,0,1,0 → out_valid reproduces 1,0,0,1,0 at 4-cycle offset.
- Random regression: 10k beats with random stall/valid against a golden model; also q=3329 (K=12, mu=5039) → 0 mismatches.
